k10_instr_enc: RTL

K10_INSTR_ENC -- requirements
Module: k10_instr_enc

---
 rtl/k10_instr_enc.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/k10_instr_enc.sv
// k10_instr_enc -- two-stage RV32I instruction word encoder.
//
// Takes decoded instruction fields plus a 32-bit immediate and produces the
// packed RV32I word together with a status code. The immediate is checked
// against the range and alignment that the target format can represent. When
// the status is not OK, the emitted word is forced to zero.
//
// Pipeline:
//   S1 : registers the request fields. Format and status are derived
//        combinationally from these registers.
//   S2 : holds the formatted word and status that drive the outputs.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds valid and its payload until that edge. The ready
// signal never depends on the valid of the same port.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_flush                synchronous flush: drops both stages on the next edge
//   i_valid / o_ready      request handshake
//   i_opcode .. i_imm      request fields (opcode, rd, rs1, rs2, funct3,
//                          funct7, csr, immediate)
//   o_valid / i_ready      result handshake
//   o_instr                encoded word (zero unless the status is OK)
//   o_err                  00 OK, 01 RANGE, 10 ALIGN, 11 UNSUP
//   o_n_ok / o_n_err       saturating counts of delivered results
module k10_instr_enc (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [11:0] i_csr,
  input  logic [31:0] i_imm,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [1:0]  o_err,
  output logic [15:0] o_n_ok,
  output logic [15:0] o_n_err
);

  // RV32I base opcodes
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_UNSUP = 2'b11;

  // Stage 1 registers
  logic        r_s1_valid;
  logic [6:0]  r_s1_opcode;
  logic [4:0]  r_s1_rd;
  logic [4:0]  r_s1_rs1;
  logic [4:0]  r_s1_rs2;
  logic [2:0]  r_s1_funct3;
  logic [6:0]  r_s1_funct7;
  logic [11:0] r_s1_csr;
  logic [31:0] r_s1_imm;

  // Stage 2 registers
  logic        r_s2_valid;
  logic [31:0] r_s2_instr;
  logic [1:0]  r_s2_err;

  logic [15:0] r_n_ok;
  logic [15:0] r_n_err;

  logic [31:0] w_fmt;
  logic        w_range;
  logic        w_align;
  logic        w_unsup;
  logic [1:0]  w_err;
  logic [31:0] w_word;
  logic        w_s2_free;
  logic        w_s1_free;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_cnt_fire;
  logic [31:0] w_imm;

  assign w_imm = r_s1_imm;

  // Format selection and range/alignment status from the S1 registers.
  // "All-equal" checks mean that the upper bits are a pure sign extension.
  always_comb begin
    w_fmt   = 32'h0;
    w_range = 1'b0;
    w_align = 1'b0;
    w_unsup = 1'b0;
    case (r_s1_opcode)
      OPC_LOAD, OPC_JALR: begin
        w_fmt   = {w_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
        w_range = !((&w_imm[31:11]) || !(|w_imm[31:11]));
      end
      OPC_OP_IMM: begin
        if (r_s1_funct3 == 3'b001 || r_s1_funct3 == 3'b101) begin
          // Shift amount is an unsigned 5-bit field; funct7 selects logical/arith.
          w_fmt   = {r_s1_funct7, w_imm[4:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
          w_range = |w_imm[31:5];
        end else begin
          w_fmt   = {w_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
          w_range = !((&w_imm[31:11]) || !(|w_imm[31:11]));
        end
      end
      OPC_STORE: begin
        w_fmt   = {w_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3, w_imm[4:0], r_s1_opcode};
        w_range = !((&w_imm[31:11]) || !(|w_imm[31:11]));
      end
      OPC_BRANCH: begin
        w_fmt   = {w_imm[12], w_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                   w_imm[4:1], w_imm[11], r_s1_opcode};
        w_align = w_imm[0];
        w_range = !((&w_imm[31:12]) || !(|w_imm[31:12]));
      end
      OPC_LUI, OPC_AUIPC: begin
        w_fmt   = {w_imm[31:12], r_s1_rd, r_s1_opcode};
        w_range = |w_imm[11:0];
      end
      OPC_JAL: begin
        w_fmt   = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], r_s1_rd, r_s1_opcode};
        w_align = w_imm[0];
        w_range = !((&w_imm[31:20]) || !(|w_imm[31:20]));
      end
      OPC_SYSTEM: begin
        w_fmt   = {r_s1_csr, w_imm[4:0], r_s1_funct3, r_s1_rd, r_s1_opcode};
        w_range = |w_imm[31:5];
      end
      OPC_OP: begin
        w_fmt = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
      end
      default: begin
        w_unsup = 1'b1;
      end
    endcase

    if (w_unsup)      w_err = ERR_UNSUP;
    else if (w_align) w_err = ERR_ALIGN;
    else if (w_range) w_err = ERR_RANGE;
    else              w_err = ERR_OK;

    w_word = (w_err == ERR_OK) ? w_fmt : 32'h0;
  end

  // Flow control: each stage is free when empty or when it drains this cycle.
  assign w_out_fire = r_s2_valid && i_ready;
  assign w_s2_free  = !r_s2_valid || i_ready;
  assign w_s1_free  = !r_s1_valid || w_s2_free;
  // Reset gates ready directly so that no request is taken while it is held.
  assign o_ready    = i_rst_n && !i_flush && w_s1_free;
  assign w_in_fire  = i_valid && o_ready;
  // A result presented during a flush is discarded, so it is not counted.
  assign w_cnt_fire = w_out_fire && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_opcode <= 7'h0;
      r_s1_rd     <= 5'h0;
      r_s1_rs1    <= 5'h0;
      r_s1_rs2    <= 5'h0;
      r_s1_funct3 <= 3'h0;
      r_s1_funct7 <= 7'h0;
      r_s1_csr    <= 12'h0;
      r_s1_imm    <= 32'h0;
    end else begin
      if (i_flush)        r_s1_valid <= 1'b0;
      else if (w_s1_free) r_s1_valid <= w_in_fire;
      if (w_in_fire) begin
        r_s1_opcode <= i_opcode;
        r_s1_rd     <= i_rd;
        r_s1_rs1    <= i_rs1;
        r_s1_rs2    <= i_rs2;
        r_s1_funct3 <= i_funct3;
        r_s1_funct7 <= i_funct7;
        r_s1_csr    <= i_csr;
        r_s1_imm    <= i_imm;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= 32'h0;
      r_s2_err   <= ERR_OK;
    end else begin
      if (i_flush)        r_s2_valid <= 1'b0;
      else if (w_s2_free) r_s2_valid <= r_s1_valid;
      // Data only moves when a real entry advances, so held outputs stay put.
      if (!i_flush && w_s2_free && r_s1_valid) begin
        r_s2_instr <= w_word;
        r_s2_err   <= w_err;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_n_ok  <= 16'h0;
      r_n_err <= 16'h0;
    end else if (w_cnt_fire) begin
      if (r_s2_err == ERR_OK) begin
        if (r_n_ok != 16'hFFFF) r_n_ok <= r_n_ok + 16'd1;
      end else begin
        if (r_n_err != 16'hFFFF) r_n_err <= r_n_err + 16'd1;
      end
    end
  end

  assign o_valid = r_s2_valid;
  assign o_instr = r_s2_instr;
  assign o_err   = r_s2_err;
  assign o_n_ok  = r_n_ok;
  assign o_n_err = r_n_err;

endmodule
